ex_muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage. It consumes the operands and decoded op held in the ID/EX pipeline register.
- While an operation runs it asserts stall_o, which drives the stall inputs of PC, IF/ID and ID/EX so the instruction stays in EX until the result is ready.
- The EX-stage result mux selects result_o when done_o=1.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ex_muldiv_unit_if.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 101 ++++++++++
 tb/tb_ex_muldiv_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and encodings for the EX-stage multiply/divide unit
package cpu_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [1:0] {
        MD_OP_NONE = 2'b00,
        MD_OP_MUL  = 2'b01,
        MD_OP_DIVU = 2'b10,
        MD_OP_REMU = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - ID/EX operand bundle and stall/result return path of the mul/div unit
//   start_i/op_i/data1_i/data2_i : instruction held in ID/EX (pipeline -> unit)
//   stall_o/done_o/result_o      : hold request, one-cycle done pulse, registered result
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, data1_i, data2_i,
        input  stall_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, data1_i, data2_i,
        output stall_o, done_o, result_o
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative shift-add multiplier / restoring divider for the EX stage
//   clk_i : clock, all state on posedge
//   rst_i : synchronous active-low reset
//   bus   : slave side of ex_muldiv_unit_if (operands in, stall/done/result out)
module ex_muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W   // 2**CNT_W must exceed WIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ex_muldiv_unit_if.slave   bus
);

    md_state_e          state, state_n;
    md_op_e             op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, opa, opb;
    logic [2*WIDTH-1:0] acc_n, opa_n, opb_n;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               rem_ge;
    logic               accept, last;

    // A NONE op never starts, so it never stalls the pipeline.
    assign accept = (state == MD_IDLE) && bus.start_i && (bus.op_i != MD_OP_NONE);
    assign last   = (state == MD_BUSY) && (cnt == CNT_W'(WIDTH - 1));

    // Divide mode register use: acc holds the partial remainder, opa[WIDTH-1:0]
    // holds the dividend shifting out at the top while quotient bits enter at
    // the bottom, opb[WIDTH-1:0] holds the divisor.
    assign rem_sh  = {acc[WIDTH-1:0], opa[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, opb[WIDTH-1:0]};
    assign rem_ge  = rem_sh >= {1'b0, opb[WIDTH-1:0]};

    always_comb begin
        acc_n = acc;
        opa_n = opa;
        opb_n = opb;
        if (op_q == MD_OP_MUL) begin
            if (opb[0]) begin
                acc_n = acc + opa;
            end
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end else begin
            acc_n = {{(WIDTH-1){1'b0}}, (rem_ge ? rem_sub : rem_sh)};
            opa_n = {opa[2*WIDTH-2:0], rem_ge};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            MD_IDLE: if (accept) state_n = MD_BUSY;
            MD_BUSY: if (last)   state_n = MD_DONE;
            MD_DONE:             state_n = MD_IDLE;
            default:             state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= MD_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            acc      <= '0;
            opa      <= '0;
            opb      <= '0;
            op_q     <= MD_OP_NONE;
            result_q <= '0;
        end else if (accept) begin
            cnt  <= '0;
            acc  <= '0;
            opa  <= {{WIDTH{1'b0}}, bus.data1_i};
            opb  <= {{WIDTH{1'b0}}, bus.data2_i};
            op_q <= md_op_e'(bus.op_i);
        end else if (state == MD_BUSY) begin
            cnt <= cnt + 1'b1;
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            if (last) begin
                result_q <= (op_q == MD_OP_DIVU) ? opa_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
            end
        end
    end

    assign bus.stall_o  = accept || (state == MD_BUSY);
    assign bus.done_o   = (state == MD_DONE);
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit with random and directed ops
module tb_ex_muldiv_unit;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [W-1:0] exp_q[$];

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            2'b01: begin
                p = 64'(a) * 64'(b);
                return p[W-1:0];
            end
            2'b10:   return (b == 0) ? {W{1'b1}} : a / b;
            2'b11:   return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Holds the instruction in ID/EX until done is seen, then returns just after
    // the edge that ends the DONE cycle (the pipeline advances there).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit wait_done);
        bit got;
        if (wait_done) exp_q.push_back(ref_model(op, a, b));
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.data1_i = a;
        bus.data2_i = b;
        if (!wait_done) return;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.done_o) got = 1'b1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout got=0 exp=1 op=%0d a=%h b=%h", op, a, b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
    endtask

    // Monitor: compares every done pulse with the scoreboard head and checks
    // the stall window length and that done is a single-cycle pulse.
    initial begin
        int  stall_run;
        bit  prev_done;
        logic [W-1:0] e;
        stall_run = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_run = 0;
            end else begin
                if (bus.stall_o) stall_run++;
                if (bus.done_o) begin
                    checks++;
                    if (prev_done) begin
                        failures++;
                        $display("FAIL done_pulse got=2+cycles exp=1cycle");
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_done got=done exp=none result=%h", bus.result_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.result_o !== e) begin
                            failures++;
                            $display("FAIL result got=%h exp=%h", bus.result_o, e);
                        end
                    end
                    check("stall_len", 32'(stall_run), 32'(W + 1));
                    stall_run = 0;
                end
            end
            prev_done = bus.done_o;
        end
    end

    initial begin
        int t0;
        logic [1:0]   op;
        logic [W-1:0] a, b;

        rst         = 1'b0;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.data1_i = '0;
        bus.data2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall",  32'(bus.stall_o), 32'd0);
        check("reset_done",   32'(bus.done_o),  32'd0);
        check("reset_result", bus.result_o,     32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(2'b01, 32'd7, 32'd6, 1'b1);
        go_idle();
        #1;
        check("idle_after_done_stall", 32'(bus.stall_o), 32'd0);
        check("result_hold", bus.result_o, 32'd42);

        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);
        issue(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b1);
        issue(2'b10, 32'd100, 32'd7, 1'b1);
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        issue(2'b10, 32'h8000_0000, 32'd1, 1'b1);
        issue(2'b10, 32'd5, 32'd0, 1'b1);
        issue(2'b11, 32'd5, 32'd0, 1'b1);
        go_idle();
        @(posedge clk);
        #1;

        // Reset in BUSY cycle 10: partial result dropped, no done pulse.
        issue(2'b01, 32'd3, 32'd3, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        check("busy_stall_before_reset", 32'(bus.stall_o), 32'd1);
        rst = 1'b0;
        go_idle();
        @(posedge clk);
        #1;
        check("midreset_stall",  32'(bus.stall_o), 32'd0);
        check("midreset_done",   32'(bus.done_o),  32'd0);
        check("midreset_result", bus.result_o,     32'd0);
        rst = 1'b1;
        issue(2'b01, 32'd2, 32'd2, 1'b1);
        go_idle();
        @(posedge clk);
        #1;

        t0 = cyc;
        issue(2'b01, 32'd3, 32'd4, 1'b1);
        issue(2'b10, 32'd9, 32'd2, 1'b1);
        check("back_to_back_cycles", 32'(cyc - t0), 32'd68);
        go_idle();

        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("op_none_stall", 32'(bus.stall_o), 32'd0);
            @(posedge clk);
            #1;
        end
        go_idle();

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(1, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            issue(op, a, b, 1'b1);
            if ($urandom_range(0, 1) == 0) begin
                go_idle();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        go_idle();
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
